register_file: RTL and testbench

//   Parametrised multi-entry register array built from single-bit storage cells.

---
 rtl/register_file.sv | 95 +++++++++
 tb/tb_register_file.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: general-purpose register array for the single-cycle datapath.
// Two combinational read ports, one clocked write port, asynchronous active-low
// clear. Entry 0 may be tied to zero (ZERO_REG=1). NUM_REGS need not be a
// power of two; indices at or above NUM_REGS read as 0 and swallow writes.
// Optional feature macro: REGFILE_BYPASS_EN forwards writeData to a read port
// addressing the register being written in the same cycle.
//
// Port timing: inputs are sampled on the rising clk edge; a write lands at that
// edge and is visible on the read ports afterwards. Reads have no handshake and
// settle combinationally from the read address.
module register_file #(
    parameter int  WIDTH    = 32,
    parameter int  NUM_REGS = 32,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] readAddrA,
    output logic [WIDTH-1:0]  readDataA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  readDataB
);

    // One extra bit so NUM_REGS itself is representable for the range check.
    localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);
    localparam bit              HAS_ZERO  = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs [NUM_REGS];

    genvar e;
    generate
        for (e = 0; e < NUM_REGS; e++) begin : g_entry
            if (HAS_ZERO && e == 0) begin : g_zero
                // Hard-wired zero: no storage, writes have nowhere to land.
                assign regs[e] = '0;
            end else begin : g_store
                logic             sel;
                logic [WIDTH-1:0] cells;

                // Only the addressed entry loads; out-of-range addresses match no entry.
                assign sel = writeEnable && (writeAddr == ADDR_W'(e));

                // Bank of WIDTH single-bit cells sharing one load enable and async clear.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        cells <= '0;
                    end else if (sel) begin
                        cells <= writeData;
                    end
                end

                assign regs[e] = cells;
            end
        end
    endgenerate

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < REG_COUNT);
    endfunction

    // Shared read mux: reset and out-of-range indices force 0.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] data;
        data = '0;
        if (reset && in_range(addr)) begin
`ifdef REGFILE_BYPASS_EN
            // Write-before-read: the zero register never forwards.
            if (writeEnable && (addr == writeAddr) &&
                !(HAS_ZERO && addr == '0)) begin
                data = writeData;
            end else begin
                data = regs[addr];
            end
`else
            data = regs[addr];
`endif
        end
        return data;
    endfunction

    // Port A read path.
    always_comb begin
        readDataA = read_port(readAddrA);
    end

    // Port B read path.
    always_comb begin
        readDataB = read_port(readAddrB);
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: three instances (zero register on, zero register
// off, NUM_REGS=24) share one stimulus. A behavioural array model predicts every
// read; a compare process checks all read ports before and after each edge.
`timescale 1ns/1ps
module tb_register_file;

    logic        clk = 1'b0;
    bit          clk_en = 1'b1;
    logic        reset = 1'b1;
    logic        writeEnable = 1'b0;
    logic [4:0]  writeAddr = '0;
    logic [31:0] writeData = '0;
    logic [4:0]  readAddrA = '0;
    logic [4:0]  readAddrB = '0;
    logic [31:0] ra_d, rb_d, ra_nz, rb_nz, ra_24, rb_24;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // model state: index 0 = default, 1 = no zero reg, 2 = 24 entries
    logic [31:0] mem [3][32];
    int          n  [3] = '{32, 32, 24};
    bit          zr [3] = '{1'b1, 1'b0, 1'b1};

    register_file dut (
        .clk(clk), .reset(reset), .writeEnable(writeEnable),
        .writeAddr(writeAddr), .writeData(writeData),
        .readAddrA(readAddrA), .readDataA(ra_d),
        .readAddrB(readAddrB), .readDataB(rb_d)
    );

    register_file #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .writeEnable(writeEnable),
        .writeAddr(writeAddr), .writeData(writeData),
        .readAddrA(readAddrA), .readDataA(ra_nz),
        .readAddrB(readAddrB), .readDataB(rb_nz)
    );

    register_file #(.NUM_REGS(24)) dut24 (
        .clk(clk), .reset(reset), .writeEnable(writeEnable),
        .writeAddr(writeAddr), .writeData(writeData),
        .readAddrA(readAddrA), .readDataA(ra_24),
        .readAddrB(readAddrB), .readDataB(rb_24)
    );

    // clock / reset
    always #5 if (clk_en) clk = ~clk;

    initial begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++)
                mem[k][a] = '0;
    end

    // model: async clear, otherwise store legal writes at the rising edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 32; a++)
                    mem[k][a] = '0;
        end else if (writeEnable) begin
            for (int k = 0; k < 3; k++)
                if (int'(writeAddr) < n[k] && !(zr[k] && writeAddr == 0))
                    mem[k][writeAddr] = writeData;
        end
    end

    function automatic logic [31:0] exp_read(int k, logic [4:0] a);
        if (!reset) return '0;
        if (int'(a) >= n[k]) return '0;
        if (zr[k] && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (writeEnable && writeAddr == a) return writeData;
`endif
        return mem[k][a];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(string ph);
        check({ph, "_dut_A"},  ra_d,  exp_read(0, readAddrA));
        check({ph, "_dut_B"},  rb_d,  exp_read(0, readAddrB));
        check({ph, "_nz_A"},   ra_nz, exp_read(1, readAddrA));
        check({ph, "_nz_B"},   rb_nz, exp_read(1, readAddrB));
        check({ph, "_r24_A"},  ra_24, exp_read(2, readAddrA));
        check({ph, "_r24_B"},  rb_24, exp_read(2, readAddrB));
    endtask

    // scoreboard: pre-edge and post-edge samples every cycle
    always begin
        @(negedge clk);
        #2;
        if (chk_en) compare_all("pre");
    end

    always begin
        @(posedge clk);
        #1;
        if (chk_en) compare_all("post");
    end

    // driver tasks
    task automatic set_in(logic we, logic [4:0] wa, logic [31:0] wd,
                          logic [4:0] ra, logic [4:0] rb);
        @(negedge clk);
        writeEnable = we;
        writeAddr   = wa;
        writeData   = wd;
        readAddrA   = ra;
        readAddrB   = rb;
    endtask

    task automatic step(logic we, logic [4:0] wa, logic [31:0] wd,
                        logic [4:0] ra, logic [4:0] rb);
        set_in(we, wa, wd, ra, rb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #20 reset = 1'b1;
        chk_en = 1'b1;

        // reset state
        step(0, 0, 0, 5, 31);
        check("reset_r5", ra_d, 32'h0);
        check("reset_r31", rb_d, 32'h0);

        // two writes, dual read in the same cycle
        step(1, 5, 32'hDEADBEEF, 0, 0);
        step(1, 31, 32'h12345678, 0, 0);
        step(0, 0, 0, 5, 31);
        check("dual_A_r5", ra_d, 32'hDEADBEEF);
        check("dual_B_r31", rb_d, 32'h12345678);
        check("same_reg_A", ra_nz, 32'hDEADBEEF);
        step(0, 0, 0, 31, 31);
        check("both_ports_r31_A", ra_d, 32'h12345678);
        check("both_ports_r31_B", rb_d, 32'h12345678);

        // zero register
        step(1, 0, 32'hFFFFFFFF, 0, 0);
        step(0, 0, 0, 0, 0);
        check("zero_reg_on", ra_d, 32'h0);
        check("zero_reg_off", ra_nz, 32'hFFFFFFFF);
        check("zero_reg_r24", rb_24, 32'h0);

        // write enable low holds contents
        step(1, 7, 32'h00000011, 7, 7);
        step(0, 7, 32'hAAAA5555, 7, 7);
        check("we_low_hold", ra_d, 32'h00000011);

        // same-cycle write/read of one index
        step(1, 3, 32'h1, 3, 3);
        set_in(1, 3, 32'h2, 3, 0);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("rw_same_pre", ra_d, 32'h2);
`else
        check("rw_same_pre", ra_d, 32'h1);
`endif
        @(posedge clk);
        #1;
        check("rw_same_post", ra_d, 32'h2);

        // bypass never applies to the zero register
        set_in(1, 0, 32'h0BAD0BAD, 0, 0);
        #2;
        check("zero_no_fwd", ra_d, 32'h0);
        @(posedge clk);
        #1;

        // pattern fill, reading the written index and its neighbour
        for (int i = 0; i < 32; i++)
            step(1, 5'(i), 32'hA5000000 + 32'(i) * 32'h00010101, 5'(i), 5'((i + 1) % 32));
        step(0, 0, 0, 5, 23);
        check("fill_r5", ra_d, 32'hA5050505);
        check("fill_r23_24", rb_24, 32'hA5171717);

        // out-of-range index on the 24-entry file
        step(1, 25, 32'h0000CAFE, 25, 23);
        check("oor_read_r24", ra_24, 32'h0);
        check("oor_write_full", ra_d, 32'h0000CAFE);
        check("oor_neighbour", rb_24, 32'hA5171717);
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 5'(i), 5'(31 - i));

        // async reset with the clock stopped
        @(negedge clk);
        #1;
        clk_en = 1'b0;
        reset  = 1'b0;
        for (int a = 0; a < 32; a++) begin
            readAddrA = 5'(a);
            readAddrB = 5'(31 - a);
            #1;
            check("noclk_rst_A", ra_d, 32'h0);
            check("noclk_rst_B", rb_d, 32'h0);
            check("noclk_rst_nz", ra_nz, 32'h0);
            check("noclk_rst_24", ra_24, 32'h0);
        end
        reset = 1'b1;
        #1;
        readAddrA = 5;
        #1;
        check("after_rst_r5", ra_d, 32'h0);
        clk_en = 1'b1;

        // reset held across an edge loses that cycle's write
        step(1, 9, 32'h00000055, 9, 9);
        check("pre_pulse_r9", ra_d, 32'h00000055);
        set_in(1, 9, 32'h00000099, 9, 9);
        #3 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("pulse_r9", ra_d, 32'h0);
        step(1, 9, 32'h00000077, 9, 9);
        check("first_write_after", ra_d, 32'h00000077);
        step(0, 0, 0, 9, 5);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
